rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//  Staged reset-release controller downstream of rst_controller. Asserts all per-stage resets
//  asynchronously and releases them in index order (0 first), waiting a fixed hold and the
//  stage's ready before the next. A stage that never reports ready raises a one-shot fault
//  into rst_controller's soc_fault inputs, so the SoC is reset again with a recorded cause.
// PARAMETERS
//  STAGES   4     number of reset domains (1..8)
//  HOLD_CYC 16    cycles between sync release / prior ready and next stage release (>=1)
//  TMO_CYC  1024  cycles a released stage may take to raise stage_rdy (>=2)
//  RDY_MASK 0     STAGES bits; bit k=1: stage k does not wait for stage_rdy[k]
// PORTS
//  clk             in   1       system clock
//  rst_ib          in   1       async active-low reset (rst_controller rst_ob[0]); async assert, sync release
//  stage_rdy       in   STAGES  stage k ready after release; synchronous to clk
//  rst_ob          out  STAGES  lo-active per-stage reset
//  done            out  1       all stages released and ready
//  seq_fault       out  1       1-cycle timeout pulse -> rst_controller soc_fault
//  seq_fault_cause out  8       `RST_CAUSE_SEQ_TMO while seq_fault, else 0
//  seq_fault_addr  out  XLEN    index of the timed-out stage, zero-extended
// BEHAVIOUR
//  - rst_ib low: immediately (no clock) rst_ob=0, done=0, seq_fault=0, cause=0, addr=0, FSM=SYNC,
//    counter=0. Applies in every state incl. mid-fault-pulse; pulse is cut.
//  - rst_ib release through 2-flop synchronizer; synced reset high at edge 2 after rst_ib rise.
//  - FSM: SYNC -> HOLD -> REL -> WAIT -> (HOLD | DONE | FAULT).
//    SYNC: wait for synced reset; then HOLD, cnt=0, k=0.
//    HOLD: count HOLD_CYC cycles; on exit edge rst_ob[k]<=1, cnt=0 (REL folded into this edge).
//    WAIT: each edge, rdy_k = stage_rdy[k] | RDY_MASK[k]. rdy_k=1: k==STAGES-1 -> DONE, done<=1;
//      else k<=k+1 -> HOLD. rdy_k=0 and cnt==TMO_CYC-1 -> FAULT. Else cnt++.
//    DONE: terminal; stage_rdy drops ignored; rst_ob stay all-1.
//    FAULT: seq_fault=1 for exactly the entry cycle, cause/addr valid with it; then held 0;
//      terminal until rst_ib asserts. rst_ob keep current values (released stages stay released).
//  - Timing, edges numbered from rst_ib rise: rst_ob[0] rises at edge 2+HOLD_CYC. stage_rdy[k]
//    sampled high at edge E -> rst_ob[k+1] rises at edge E+HOLD_CYC; done rises at E for the last stage.
//    Masked stage released at edge R is treated ready at R+1.
//  - Timeout: stage released at edge R, stage_rdy[k] low through edge R+TMO_CYC -> seq_fault high
//    from edge R+TMO_CYC for one cycle.
//  - rst_ob bits only rise in order; never two stages released on the same edge; rst_ob[j]=1 implies
//    rst_ob[i]=1 for all i<j.
//  - Counter width $clog2(max(HOLD_CYC,TMO_CYC)+1); no wrap possible. Stage index width $clog2(STAGES)
//    (min 1).
// STRUCTURE
//  - femto.vh: add `RST_CAUSE_SEQ_TMO (8-bit, distinct from POR/HW/SW causes); XLEN from same header.
//  - FSM state encoding as localparams inside module.
//  - One sub-module: rst_sync (2-flop async-assert/sync-deassert synchronizer, reusable elsewhere).
// TESTING (STAGES=3, HOLD_CYC=4, TMO_CYC=8, RDY_MASK=0 unless noted)
//  1 rst_ib rises edge 0, stage_rdy tied 3'b111 -> rst_ob[0] @6, [1] @11, [2] @16, done @17.
//  2 stage_rdy[1] rises 3 edges after rst_ob[1] -> rst_ob[2] exactly 4 edges after that sample; no fault.
//  3 stage_rdy[1] stuck 0 -> seq_fault 1 cycle at R1+8, cause=`RST_CAUSE_SEQ_TMO, addr=1,
//    rst_ob=3'b011 held, no second pulse over 100 cycles.
//  4 rst_ib low mid-HOLD and during the fault pulse -> same cycle rst_ob=0, seq_fault=0; re-release
//    reproduces scenario 1 timing.
//  5 RDY_MASK=3'b010, stage_rdy=3'b101 -> stage 1 skips wait, rst_ob[2] at rst_ob[1]+1+4, done ok.
//  6 Assertion run: rst_ob in-order monotonic, seq_fault width 1, done implies rst_ob all-1.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared constants and sizing helpers for the staged reset-release sequencer.
//  - XLEN             : width of the fault address bus feeding the SoC fault logger
//  - RST_CAUSE_*      : 8-bit reset cause codes; SEQ_TMO must stay distinct from POR/HW/SW
//  - cnt_width()      : width of a counter that must reach max(hold, tmo) without wrapping
//  - idx_width()      : width of a stage index, never narrower than 1 bit
package rst_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0] RST_CAUSE_POR     = 8'h01;
  localparam logic [7:0] RST_CAUSE_HW      = 8'h02;
  localparam logic [7:0] RST_CAUSE_SW      = 8'h03;
  localparam logic [7:0] RST_CAUSE_SEQ_TMO = 8'h04;

  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
    int unsigned m;
    m = (hold > tmo) ? hold : tmo;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sequencer_rst_sync.sv
// rst_sync: two-flop reset synchronizer, asynchronous assert / synchronous release.
// Ports:
//  clk         in  clock of the destination domain
//  arst_n      in  asynchronous active-low reset
//  sync_rst_n  out active-low reset, drops with arst_n, rises on the 2nd clk edge after arst_n rises
module rst_sync (
  input  logic clk,
  input  logic arst_n,
  output logic sync_rst_n
);

  logic meta_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_reg   <= 1'b0;
      sync_rst_n <= 1'b0;
    end else begin
      meta_reg   <= 1'b1;
      sync_rst_n <= meta_reg;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases per-stage resets one at a time in index order once the
// upstream reset is released. Each release waits HOLD_CYC cycles after the previous
// event, then the released stage must report ready within TMO_CYC cycles or a
// single-cycle fault pulse is raised for the upstream reset controller.
// Ports:
//  clk             in   system clock
//  rst_ib          in   asynchronous active-low reset (async assert, sync release inside)
//  stage_rdy       in   [STAGES] per-stage ready, synchronous to clk
//  rst_ob          out  [STAGES] active-low per-stage resets, released in order
//  done            out  all stages released and ready
//  seq_fault       out  one-cycle timeout pulse
//  seq_fault_cause out  [8] RST_CAUSE_SEQ_TMO during the pulse, else 0
//  seq_fault_addr  out  [XLEN] index of the timed-out stage during the pulse, else 0
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned       STAGES   = 4,
  parameter int unsigned       HOLD_CYC = 16,
  parameter int unsigned       TMO_CYC  = 1024,
  parameter logic [STAGES-1:0] RDY_MASK = '0
) (
  input  logic              clk,
  input  logic              rst_ib,
  input  logic [STAGES-1:0] stage_rdy,
  output logic [STAGES-1:0] rst_ob,
  output logic              done,
  output logic              seq_fault,
  output logic [7:0]        seq_fault_cause,
  output logic [XLEN-1:0]   seq_fault_addr
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, TMO_CYC);
  localparam int unsigned IDX_W = idx_width(STAGES);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(STAGES - 1);

  // The release of a stage happens on the HOLD exit edge, so there is no
  // separate release state to occupy.
  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             sync_rst_n;
  logic             rdy_k;

  rst_sync u_rst_sync (
    .clk        (clk),
    .arst_n     (rst_ib),
    .sync_rst_n (sync_rst_n)
  );

  // Masked stages count as ready on the first WAIT edge.
  assign rdy_k = stage_rdy[idx_reg] | RDY_MASK[idx_reg];

  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      state_reg       <= ST_SYNC;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      rst_ob          <= '0;
      done            <= 1'b0;
      seq_fault       <= 1'b0;
      seq_fault_cause <= '0;
      seq_fault_addr  <= '0;
    end else begin
      // Fault outputs are pulses: anything that does not re-assert them clears them.
      seq_fault       <= 1'b0;
      seq_fault_cause <= '0;
      seq_fault_addr  <= '0;
      case (state_reg)
        ST_SYNC: begin
          // The synchronizer output rose one edge ago; that edge already counts
          // as the first hold cycle, so stage 0 is released HOLD_CYC edges after it.
          if (sync_rst_n) begin
            idx_reg <= '0;
            if (HOLD_CYC == 1) begin
              rst_ob[0] <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= ST_WAIT;
            end else begin
              cnt_reg   <= CNT_W'(1);
              state_reg <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            rst_ob[idx_reg] <= 1'b1;
            cnt_reg         <= '0;
            state_reg       <= ST_WAIT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (rdy_k) begin
            cnt_reg <= '0;
            if (idx_reg == LAST_STAGE) begin
              done      <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= ST_HOLD;
            end
          end else if (cnt_reg == TMO_LAST) begin
            seq_fault       <= 1'b1;
            seq_fault_cause <= RST_CAUSE_SEQ_TMO;
            seq_fault_addr  <= XLEN'(idx_reg);
            state_reg       <= ST_FAULT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // Both are terminal until rst_ib asserts; rst_ob keeps its value.
        ST_DONE:  state_reg <= ST_DONE;
        ST_FAULT: state_reg <= ST_FAULT;
        default:  state_reg <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer (STAGES=3, HOLD_CYC=4, TMO_CYC=8).
// Instance a: RDY_MASK=0, instance b: RDY_MASK=3'b010. A timing model counts
// edges since reset release and derives release/ready/timeout events from them;
// one negedge process compares both instances against it every cycle.
module tb_rst_sequencer;
  import rst_sequencer_pkg::*;

  localparam int          NST    = 3;
  localparam int          HOLD   = 4;
  localparam int          TMO    = 8;
  localparam logic [2:0]  MASK_A = 3'b000;
  localparam logic [2:0]  MASK_B = 3'b010;

  logic        clk;
  logic        rst_a, rst_b;
  logic [2:0]  rdy_a, rdy_b;
  logic [2:0]  rob_a, rob_b;
  logic        done_a, done_b;
  logic        f_a, f_b;
  logic [7:0]  cause_a, cause_b;
  logic [31:0] addr_a, addr_b;

  int errors = 0;
  int checks = 0;

  rst_sequencer #(.STAGES(NST), .HOLD_CYC(HOLD), .TMO_CYC(TMO), .RDY_MASK(MASK_A)) u_a (
    .clk(clk), .rst_ib(rst_a), .stage_rdy(rdy_a), .rst_ob(rob_a), .done(done_a),
    .seq_fault(f_a), .seq_fault_cause(cause_a), .seq_fault_addr(addr_a)
  );

  rst_sequencer #(.STAGES(NST), .HOLD_CYC(HOLD), .TMO_CYC(TMO), .RDY_MASK(MASK_B)) u_b (
    .clk(clk), .rst_ib(rst_b), .stage_rdy(rdy_b), .rst_ob(rob_b), .done(done_b),
    .seq_fault(f_b), .seq_fault_cause(cause_b), .seq_fault_addr(addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- timing model ----------------
  int         e_cnt[2];
  int         next_rel[2];
  int         rel_edge[2];
  int         k_idx[2];
  int         fault_edge[2];
  bit         waiting[2];
  bit         m_done[2];
  bit         m_fault[2];
  logic [2:0] m_rob[2];

  task automatic model_reset(input int i);
    e_cnt[i]      = 0;
    next_rel[i]   = 2 + HOLD;
    rel_edge[i]   = 0;
    k_idx[i]      = 0;
    fault_edge[i] = -1;
    waiting[i]    = 1'b0;
    m_done[i]     = 1'b0;
    m_fault[i]    = 1'b0;
    m_rob[i]      = '0;
  endtask

  task automatic model_step(input int i, input logic [2:0] rdy, input logic [2:0] mask);
    e_cnt[i]++;
    if (m_done[i] || m_fault[i]) return;
    if (!waiting[i]) begin
      if (e_cnt[i] == next_rel[i]) begin
        m_rob[i][k_idx[i]] = 1'b1;
        rel_edge[i] = e_cnt[i];
        waiting[i]  = 1'b1;
      end
    end else if (rdy[k_idx[i]] || mask[k_idx[i]]) begin
      if (k_idx[i] == NST - 1) m_done[i] = 1'b1;
      else begin
        k_idx[i]++;
        next_rel[i] = e_cnt[i] + HOLD;
        waiting[i]  = 1'b0;
      end
    end else if (e_cnt[i] == rel_edge[i] + TMO) begin
      m_fault[i]    = 1'b1;
      fault_edge[i] = e_cnt[i];
    end
  endtask

  always @(posedge clk) begin
    if (rst_a) model_step(0, rdy_a, MASK_A); else model_reset(0);
    if (rst_b) model_step(1, rdy_b, MASK_B); else model_reset(1);
  end

  // ---------------- observation + compare ----------------
  int         rise_e[2][3];
  int         done_e[2];
  int         fault_e[2];
  int         pulses[2];
  logic [7:0] pulse_cause[2];
  logic [31:0] pulse_addr[2];
  logic [2:0] prev_rob[2];
  logic       prev_rst[2];
  logic       prev_f[2];
  logic       prev_done[2];

  task automatic clear_obs(input int i);
    for (int j = 0; j < 3; j++) rise_e[i][j] = -1;
    done_e[i]      = -1;
    fault_e[i]     = -1;
    pulses[i]      = 0;
    pulse_cause[i] = '0;
    pulse_addr[i]  = '0;
  endtask

  task automatic compare(input int i, input logic rst, input logic [2:0] rob, input logic dn,
                         input logic f, input logic [7:0] c, input logic [31:0] a);
    logic [2:0]  xr;
    logic        xd, xf;
    logic [7:0]  xc;
    logic [31:0] xa;
    string       tag;
    tag = (i == 0) ? "a" : "b";
    if (!rst) begin
      xr = '0; xd = 1'b0; xf = 1'b0; xc = '0; xa = '0;
    end else begin
      xr = m_rob[i];
      xd = m_done[i];
      xf = m_fault[i] && (e_cnt[i] == fault_edge[i]);
      xc = xf ? RST_CAUSE_SEQ_TMO : 8'h00;
      xa = xf ? 32'(k_idx[i]) : 32'h0;
    end
    chk($sformatf("%s.rst_ob@e%0d", tag, e_cnt[i]), 32'(rob), 32'(xr));
    chk($sformatf("%s.done@e%0d", tag, e_cnt[i]), 32'(dn), 32'(xd));
    chk($sformatf("%s.seq_fault@e%0d", tag, e_cnt[i]), 32'(f), 32'(xf));
    chk($sformatf("%s.cause@e%0d", tag, e_cnt[i]), 32'(c), 32'(xc));
    chk($sformatf("%s.addr@e%0d", tag, e_cnt[i]), a, xa);
    // Structural properties of the outputs themselves
    chk($sformatf("%s.in_order", tag), 32'((4'(rob) + 4'd1) & 4'(rob)), 32'h0);
    if (rst && prev_rst[i]) chk($sformatf("%s.monotonic", tag), 32'(prev_rob[i] & ~rob), 32'h0);
    chk($sformatf("%s.fault_width", tag), 32'(prev_f[i] & f), 32'h0);
    if (dn) chk($sformatf("%s.done_all", tag), 32'(rob), 32'h7);
    for (int j = 0; j < 3; j++)
      if (rob[j] && !prev_rob[i][j] && rise_e[i][j] < 0) rise_e[i][j] = e_cnt[i];
    if (dn && !prev_done[i] && done_e[i] < 0) done_e[i] = e_cnt[i];
    if (f && !prev_f[i]) begin
      pulses[i]++;
      fault_e[i]     = e_cnt[i];
      pulse_cause[i] = c;
      pulse_addr[i]  = a;
    end
    prev_rob[i]  = rob;
    prev_rst[i]  = rst;
    prev_f[i]    = f;
    prev_done[i] = dn;
  endtask

  always @(negedge clk) begin
    compare(0, rst_a, rob_a, done_a, f_a, cause_a, addr_a);
    compare(1, rst_b, rob_b, done_b, f_b, cause_b, addr_b);
  end

  // ---------------- stimulus helpers ----------------
  task automatic release_rst(input bit do_a, input bit do_b);
    @(negedge clk);
    #2;
    if (do_a) begin clear_obs(0); rst_a = 1'b1; end
    if (do_b) begin clear_obs(1); rst_b = 1'b1; end
  endtask

  // Returns at the negedge following model edge n of instance i.
  task automatic wait_edge(input int i, input int n);
    int guard;
    guard = 0;
    while (e_cnt[i] < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic drop_a(input string tag);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    chk({tag, ".async_rob"}, 32'(rob_a), 32'h0);
    chk({tag, ".async_done"}, 32'(done_a), 32'h0);
    chk({tag, ".async_fault"}, 32'(f_a), 32'h0);
    chk({tag, ".async_cause"}, 32'(cause_a), 32'h0);
    chk({tag, ".async_addr"}, addr_a, 32'h0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_s1_timing(input int i, input string tag);
    chk({tag, ".rise0"}, rise_e[i][0], 6);
    chk({tag, ".rise1"}, rise_e[i][1], 11);
    chk({tag, ".rise2"}, rise_e[i][2], 16);
    chk({tag, ".done_edge"}, done_e[i], 17);
    chk({tag, ".pulses"}, pulses[i], 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    rdy_a = '0;   rdy_b = '0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      clear_obs(i);
      prev_rob[i] = '0; prev_rst[i] = 1'b0; prev_f[i] = 1'b0; prev_done[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rob_a", 32'(rob_a), 32'h0);
    chk("reset.done_a", 32'(done_a), 32'h0);

    // 1 + 5: all ready on a; b has stage 1 masked and never ready
    rdy_a = 3'b111;
    rdy_b = 3'b101;
    release_rst(1'b1, 1'b1);
    wait_edge(0, 25);
    check_s1_timing(0, "s1");
    check_s1_timing(1, "s5");
    $display("scenario 1/5: a rise %0d %0d %0d done %0d; b rise %0d %0d %0d done %0d",
             rise_e[0][0], rise_e[0][1], rise_e[0][2], done_e[0],
             rise_e[1][0], rise_e[1][1], rise_e[1][2], done_e[1]);

    // 2: stage 1 becomes ready 3 edges after its release (sampled at edge 14)
    drop_a("s2pre");
    rdy_a = 3'b101;
    release_rst(1'b1, 1'b0);
    wait_edge(0, 13);
    rdy_a[1] = 1'b1;
    wait_edge(0, 30);
    chk("s2.rise1", rise_e[0][1], 11);
    chk("s2.rise2", rise_e[0][2], 18);
    chk("s2.done_edge", done_e[0], 19);
    chk("s2.pulses", pulses[0], 0);
    $display("scenario 2: rise2 %0d done %0d", rise_e[0][2], done_e[0]);

    // 3: stage 1 never ready -> timeout at 11+8
    drop_a("s3pre");
    rdy_a = 3'b001;
    release_rst(1'b1, 1'b0);
    wait_edge(0, 120);
    chk("s3.fault_edge", fault_e[0], 19);
    chk("s3.pulses", pulses[0], 1);
    chk("s3.cause", 32'(pulse_cause[0]), 32'(RST_CAUSE_SEQ_TMO));
    chk("s3.addr", pulse_addr[0], 1);
    chk("s3.rob_held", 32'(rob_a), 32'h3);
    chk("s3.rise2", rise_e[0][2], -1);
    $display("scenario 3: fault edge %0d pulses %0d", fault_e[0], pulses[0]);

    // 4a: reset mid-HOLD of stage 1, then re-release reproduces scenario 1
    drop_a("s4pre");
    rdy_a = 3'b111;
    release_rst(1'b1, 1'b0);
    wait_edge(0, 8);
    @(posedge clk);
    #2;
    chk("s4.rob_before", 32'(rob_a), 32'h1);
    rst_a = 1'b0;
    #1;
    chk("s4.hold_rob", 32'(rob_a), 32'h0);
    chk("s4.hold_done", 32'(done_a), 32'h0);
    repeat (3) @(posedge clk);
    release_rst(1'b1, 1'b0);
    wait_edge(0, 25);
    check_s1_timing(0, "s4");

    // 4b: reset during the fault pulse cuts it
    drop_a("s4bpre");
    rdy_a = 3'b001;
    release_rst(1'b1, 1'b0);
    wait_edge(0, 18);
    @(posedge clk);
    #2;
    chk("s4b.pulse_before", 32'(f_a), 32'h1);
    chk("s4b.cause_before", 32'(cause_a), 32'(RST_CAUSE_SEQ_TMO));
    rst_a = 1'b0;
    #1;
    chk("s4b.cut_fault", 32'(f_a), 32'h0);
    chk("s4b.cut_cause", 32'(cause_a), 32'h0);
    chk("s4b.cut_addr", addr_a, 32'h0);
    chk("s4b.cut_rob", 32'(rob_a), 32'h0);
    repeat (3) @(posedge clk);
    $display("scenario 4: reset mid-hold and mid-pulse handled");

    // b has sat in its terminal state throughout
    chk("s5.still_done", 32'(done_b), 32'h1);
    chk("s5.still_rob", 32'(rob_b), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
